aes_inv_key_sched: RTL and testbench
====================================

// Module: aes_inv_key_sched
// PURPOSE
//  AES-128 inverse key scheduler for the decryption datapath. Steps round keys backwards, one per accepted handshake.
//  Loads the round-10 key and emits keys for rounds 10,9,...,0 on a valid/ready stream.
//  The inverse cipher consumes this stream directly, so no 11-entry key RAM is needed.
//  Each backward step uses Rcon(r), the same round-constant values as the forward key expansion.
// PARAMETERS
//  KEY_W  128  key/round-key width; only 128 legal
//  NR     10   number of rounds; only 10 legal (AES-128)
// PORTS
//  clk_i         in   1    single clock, rising edge
//  rst_ni        in   1    asynchronous, active-low reset
//  start_i       in   1    load key_i and begin a sequence (IDLE only)
//  abort_i       in   1    drop current sequence, return to IDLE
//  key_i         in   128  round-10 key (cipher key if AES_INV_KEY_PRECOMP_EN)
//  rkey_o        out  128  current round key, word0 in [127:96]
//  round_o       out  4    round index of rkey_o (10..0)
//  rkey_valid_o  out  1    rkey_o/round_o valid
//  rkey_ready_i  in   1    consumer accepts rkey_o this cycle
//  busy_o        out  1    state != IDLE
//  done_o        out  1    1-cycle pulse after round-0 key accepted
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE; rkey_o=0, round_o=0, rkey_valid_o=0, busy_o=0, done_o=0.
//  States: IDLE, [PRECOMP], RUN.
//  - IDLE: start_i=1 -> rkey<=key_i, round<=10, ->RUN; rkey_valid_o=1 from the next cycle.
//  - RUN: rkey_valid_o=1. Transfer = valid & rkey_ready_i.
//    - Transfer, round>0: rkey <= inv_step(rkey, round), round <= round-1. Zero-bubble: valid stays 1.
//    - Transfer, round==0: ->IDLE, valid<=0, done_o=1 for one cycle.
//    - No transfer: rkey_o/round_o held stable; valid never drops without a transfer.
//  inv_step (w0..w3 = rkey words, r = round):
//    n3=w3^w2; n2=w2^w1; n1=w1^w0;
//    n0 = w0 ^ SubWord(RotWord(n3)) ^ Rcon(r).
//    Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the MS byte, 0 in the rest.
//  Priorities and edge cases:
//  - abort_i beats every other input in every state: ->IDLE next cycle, valid<=0, no done_o.
//  - start_i outside IDLE is ignored. start_i with abort_i in IDLE: stay IDLE.
//  - start_i in the cycle done_o is high is ignored (state is IDLE only on the following cycle).
//  - round_o never wraps below 0.
//  - Reset mid-sequence clears immediately; no partial key is held.
// CONFIGURATION
//  AES_INV_KEY_PRECOMP_EN:
//  - Defined: key_i is the cipher key. start_i -> PRECOMP, which runs 10 forward expansion steps,
//    one per cycle, with round counting 1..10.
//    Forward step: n0=w0^SubWord(RotWord(w3))^Rcon(r); n1=w1^n0; n2=w2^n1; n3=w3^n2.
//    The S-box bank is shared with the inverse step through an input mux (w3 vs w3^w2).
//    Then ->RUN with round_o=10. rkey_valid_o rises 11 cycles after the start_i edge.
//    abort_i during PRECOMP -> IDLE. busy_o=1 during PRECOMP.
//  - Undefined: no PRECOMP state; key_i is the round-10 key; valid rises 1 cycle after start_i.
// STRUCTURE
//  - aes_pkg: AES_NR=10, KEY_W=128, Rcon table as a function rcon(r[3:0]) (0 for r=0 or r>10), state encoding.
//  - Sub-module aes_sbox (combinational byte S-box), instantiated 4x for SubWord.
//  - Everything else is inline: the step logic, 4-bit round counter and 2-bit state register.
// TESTING
//  Test vectors are from the FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c.
//  1. start, key_i=d014f9a8 c9ee2589 e13f0cc8 b6630ca6, ready=1 always.
//     -> keys for rounds 10..0 on 11 consecutive cycles, round 9 = ac7766f3 19fadc21 28d12941 575c006e,
//        round 1 = a0fafe17 88542cb1 23a33939 2a6c7605, round 0 = cipher key;
//        done_o pulses 1 cycle after the last transfer.
//  2. Same as 1 with random ready stalls -> rkey_o/round_o stable while ready=0; the same 11 keys in order.
//  3. abort_i at round 6, with ready=1 in the same cycle -> valid=0 next cycle, no done_o;
//     a new start reproduces round 10 correctly.
//  4. start_i pulses during RUN and in the done_o cycle -> ignored; sequence and key values unchanged.
//  5. rst_ni low mid-RUN (asynchronous, between edges) -> all outputs 0 immediately; IDLE after release.
//  6. AES_INV_KEY_PRECOMP_EN, key_i=2b7e1516 28aed2a6 abf71588 09cf4f3c
//     -> valid rises at start+11 with rkey_o=d014f9a8 c9ee2589 e13f0cc8 b6630ca6; then matches test 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, scheduler state encoding and the round-constant table.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int KEY_W  = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRECOMP = 2'b01,
    ST_RUN     = 2'b10
  } state_e;

  // Rcon(r) most-significant byte; rounds outside 1..10 carry no constant.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry 0 sits in the most-significant byte, so byte index = 255 - x = ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[~x];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key scheduler: streams round keys 10..0 over valid/ready.
// Define AES_INV_KEY_PRECOMP_EN to load the cipher key and expand it forward first.
module aes_inv_key_sched #(
  parameter int KEY_W = 128,
  parameter int NR    = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [KEY_W-1:0] key_i,
  output logic [KEY_W-1:0] rkey_o,
  output logic [3:0]       round_o,
  output logic             rkey_valid_o,
  input  logic             rkey_ready_i,
  output logic             busy_o,
  output logic             done_o
);
  import aes_pkg::*;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] rkey_q, rkey_d;
  logic [3:0]       round_q, round_d;
  logic             done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sb_word, rot_word, sub_word, n0;
  logic [KEY_W-1:0] inv_key;

  assign {w0, w1, w2, w3} = rkey_q;

  // One S-box bank serves both directions; only its input word differs.
`ifdef AES_INV_KEY_PRECOMP_EN
  assign sb_word = (state_q == ST_PRECOMP) ? w3 : (w3 ^ w2);
`else
  assign sb_word = w3 ^ w2;
`endif
  assign rot_word = {sb_word[23:0], sb_word[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .x(rot_word[8*i +: 8]),
      .y(sub_word[8*i +: 8])
    );
  end

  assign n0      = w0 ^ sub_word ^ {rcon(round_q), 24'h000000};
  assign inv_key = {n0, w1 ^ w0, w2 ^ w1, w3 ^ w2};

`ifdef AES_INV_KEY_PRECOMP_EN
  logic [31:0]      f1, f2, f3;
  logic [KEY_W-1:0] fwd_key;
  assign f1      = w1 ^ n0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {n0, f1, f2, f3};
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d = state_q;
    rkey_d  = rkey_q;
    round_d = round_q;
    done_d  = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // done_q high means the last key was just taken; a start here is ignored.
          if (start_i && !done_q) begin
            rkey_d = key_i;
`ifdef AES_INV_KEY_PRECOMP_EN
            round_d = 4'd1;
            state_d = ST_PRECOMP;
`else
            round_d = 4'(NR);
            state_d = ST_RUN;
`endif
          end
        end
`ifdef AES_INV_KEY_PRECOMP_EN
        ST_PRECOMP: begin
          rkey_d = fwd_key;
          if (round_q == 4'(NR)) state_d = ST_RUN;
          else                   round_d = round_q + 4'd1;
        end
`endif
        ST_RUN: begin
          if (rkey_ready_i) begin
            if (round_q == 4'd0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              rkey_d  = inv_key;
              round_d = round_q - 4'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rkey_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rkey_q  <= rkey_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign rkey_o       = rkey_q;
  assign round_o      = round_q;
  assign rkey_valid_o = (state_q == ST_RUN);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched using the FIPS-197 A.1 key expansion.
module tb_aes_inv_key_sched;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] rkey_o;
  logic [3:0]   round_o;
  logic         rkey_valid_o;
  logic         rkey_ready_i = 1'b0;
  logic         busy_o;
  logic         done_o;

`ifdef AES_INV_KEY_PRECOMP_EN
  localparam logic [127:0] LOAD_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam int           LAT      = 11;
`else
  localparam logic [127:0] LOAD_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int           LAT      = 1;
`endif

  aes_inv_key_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .key_i(key_i), .rkey_o(rkey_o), .round_o(round_o), .rkey_valid_o(rkey_valid_o),
    .rkey_ready_i(rkey_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] key;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  function automatic logic [127:0] exp_key(input int r);
    case (r)
      0:  exp_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      1:  exp_key = 128'ha0fafe1788542cb123a339392a6c7605;
      2:  exp_key = 128'hf2c295f27a96b9435935807a7359f67f;
      3:  exp_key = 128'h3d80477d4716fe3e1e237e446d7a883b;
      4:  exp_key = 128'hef44a541a8525b7fb671253bdb0bad00;
      5:  exp_key = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      6:  exp_key = 128'h6d88a37a110b3efddbf98641ca0093fd;
      7:  exp_key = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      8:  exp_key = 128'head27321b58dbad2312bf5607f8d292f;
      9:  exp_key = 128'hac7766f319fadc2128d12941575c006e;
      default: exp_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_seq();
    key_i   = LOAD_KEY;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int r = 10; r >= 0; r--) exp_q.push_back('{round: 4'(r), key: exp_key(r)});
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!rkey_valid_o && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done_o && n < 400) begin
      step();
      n++;
    end
    check(name, 128'(done_o), 128'd1);
  endtask

  // Monitor: pops an expectation on every transfer, and checks holds during stalls.
  initial begin
    logic         hold_vld;
    logic [3:0]   hold_round;
    logic [127:0] hold_key;
    exp_t         e;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (done_o) done_cnt++;
        if (hold_vld && rkey_valid_o) begin
          check("hold_round", 128'(round_o), 128'(hold_round));
          check("hold_key", rkey_o, hold_key);
        end
        if (rkey_valid_o && rkey_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got round %0d, want no transfer", round_o);
          end else begin
            e = exp_q.pop_front();
            check("sb_round", 128'(round_o), 128'(e.round));
            check("sb_key", rkey_o, e.key);
          end
        end
        hold_vld   = rkey_valid_o && !rkey_ready_i && !abort_i;
        hold_round = round_o;
        hold_key   = rkey_o;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;

    // Reset state
    #12;
    check("rst_valid", 128'(rkey_valid_o), 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_done", 128'(done_o), 128'd0);
    check("rst_round", 128'(round_o), 128'd0);
    check("rst_key", rkey_o, 128'd0);
    #5 rst_ni = 1'b1;
    step();

    // 1: full sequence, ready always high
    rkey_ready_i = 1'b1;
    start_seq();
    wait_valid(n);
    check("valid_latency", 128'(n), 128'(LAT));
    check("first_round", 128'(round_o), 128'd10);
    wait_done("t1_done", n);
    check("done_latency", 128'(n), 128'd11);
    check("t1_drained", 128'(exp_q.size()), 128'd0);
    step();
    check("done_pulse", 128'(done_o), 128'd0);
    check("t1_idle", 128'(busy_o), 128'd0);

    // 2: random ready stalls
    start_seq();
    n = 0;
    while (!done_o && n < 600) begin
      rkey_ready_i = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("t2_done", 128'(done_o), 128'd1);
    check("t2_drained", 128'(exp_q.size()), 128'd0);
    rkey_ready_i = 1'b1;
    step();

    // 3: abort at round 6 with ready high
    start_seq();
    wait_valid(n);
    repeat (4) step();
    check("abort_round", 128'(round_o), 128'd6);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort_valid", 128'(rkey_valid_o), 128'd0);
    check("abort_busy", 128'(busy_o), 128'd0);
    d0 = done_cnt;
    repeat (3) step();
    check("abort_no_done", 128'(done_cnt), 128'(d0));
    exp_q.delete();
    start_seq();
    wait_valid(n);
    check("restart_key", rkey_o, exp_key(10));
    wait_done("t3_done", n);
    check("t3_drained", 128'(exp_q.size()), 128'd0);
    step();

    // 4: start pulses during RUN and in the done cycle are ignored
    start_seq();
    wait_valid(n);
    repeat (2) step();
    start_i = 1'b1;
    repeat (2) step();
    start_i = 1'b0;
    wait_done("t4_done", n);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("done_start_busy", 128'(busy_o), 128'd0);
    repeat (2) step();
    check("done_start_valid", 128'(rkey_valid_o), 128'd0);
    check("t4_drained", 128'(exp_q.size()), 128'd0);

    // 5: asynchronous reset mid-RUN
    start_seq();
    wait_valid(n);
    repeat (3) step();
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid", 128'(rkey_valid_o), 128'd0);
    check("arst_busy", 128'(busy_o), 128'd0);
    check("arst_round", 128'(round_o), 128'd0);
    check("arst_key", rkey_o, 128'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    step();
    check("arst_idle", 128'(busy_o), 128'd0);
    check("arst_idle_valid", 128'(rkey_valid_o), 128'd0);
    start_seq();
    wait_valid(n);
    check("post_rst_latency", 128'(n), 128'(LAT));
    wait_done("t5_done", n);
    check("t5_drained", 128'(exp_q.size()), 128'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
